// File: rtl/debug_pkg.sv
// Shared constants, state encoding and the logical control-word layout for
// the byte-stream debug command engine.
package debug_pkg;

    localparam logic [7:0] CMD_ENTER  = 8'h01;
    localparam logic [7:0] CMD_EXEC   = 8'h02;
    localparam logic [7:0] CMD_EXIT   = 8'h03;
    localparam logic [7:0] CMD_STATUS = 8'h04;

    localparam logic [7:0] RSP_ENTER_OK  = 8'hA5;
    localparam logic [7:0] RSP_EXIT_OK   = 8'h5A;
    localparam logic [7:0] RSP_NOT_ACKED = 8'hE1;
    localparam logic [7:0] RSP_ENTER_TO  = 8'hE2;
    localparam logic [7:0] RSP_EXIT_TO   = 8'hE3;
    localparam logic [7:0] RSP_BAD_CMD   = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARGS,
        ST_REQ,
        ST_EXEC,
        ST_REL,
        ST_RESP
    } state_t;

    localparam int W0_CLR = 7;
    localparam int W0_HLT = 6;
    localparam int W0_CE  = 5;
    localparam int W0_SU  = 4;
    localparam int W0_DO  = 3;

    localparam int W1_AI = 7;
    localparam int W1_BI = 6;
    localparam int W1_OI = 5;
    localparam int W1_II = 4;
    localparam int W1_J  = 3;
    localparam int W1_FI = 2;
    localparam int W1_MI = 1;
    localparam int W1_RI = 0;

    localparam int W2_AO = 7;
    localparam int W2_BO = 6;
    localparam int W2_IO = 5;
    localparam int W2_CO = 4;
    localparam int W2_EO = 3;
    localparam int W2_RO = 2;
    localparam int W2_NO = 1;

    // Logical control word, 1 = assert, independent of pin polarity.
    typedef struct packed {
        logic clr, hlt, ce, su, dato;
        logic ai, bi, oi, ii, j, fi, mi, ri;
        logic ao, bo, io, co, eo, ro, no;
    } ctrl_word_t;

endpackage

// File: rtl/debug_port_if.sv
// RX/TX byte handshakes of the debug port. A byte moves on a clock edge where
// VALID and READY are both high; VALID holds its data stable until then.
interface debug_port_if;

    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    modport master (
        output RX_DATA, RX_VALID, TX_READY,
        input  RX_READY, TX_DATA, TX_VALID
    );

    modport slave (
        input  RX_DATA, RX_VALID, TX_READY,
        output RX_READY, TX_DATA, TX_VALID
    );

endinterface

// File: rtl/debug_word_drive.sv
// Maps the registered logical control word onto the core's physical debug pins;
// when not enabled every pin sits at its idle (deasserted) level.
module debug_word_drive
    import debug_pkg::*;
(
    input  ctrl_word_t i_word,
    input  logic [7:0] i_data,
    input  logic       i_en,
    output logic       o_clr,
    output logic       o_hlt,
    output logic       o_ce,
    output logic       o_su,
    output logic       o_ri,
    output logic       o_ai_n,
    output logic       o_bi_n,
    output logic       o_oi_n,
    output logic       o_ii_n,
    output logic       o_j_n,
    output logic       o_fi_n,
    output logic       o_mi_n,
    output logic       o_do_n,
    output logic       o_ao_n,
    output logic       o_bo_n,
    output logic       o_io_n,
    output logic       o_co_n,
    output logic       o_eo_n,
    output logic       o_ro_n,
    output logic       o_no_n,
    output logic [7:0] o_data
);

    ctrl_word_t w_act;

    assign w_act  = i_en ? i_word : '0;
    assign o_data = i_en ? i_data : 8'h00;

    assign o_clr  = w_act.clr;
    assign o_hlt  = w_act.hlt;
    assign o_ce   = w_act.ce;
    assign o_su   = w_act.su;
    assign o_ri   = w_act.ri;

    assign o_ai_n = ~w_act.ai;
    assign o_bi_n = ~w_act.bi;
    assign o_oi_n = ~w_act.oi;
    assign o_ii_n = ~w_act.ii;
    assign o_j_n  = ~w_act.j;
    assign o_fi_n = ~w_act.fi;
    assign o_mi_n = ~w_act.mi;
    assign o_do_n = ~w_act.dato;
    assign o_ao_n = ~w_act.ao;
    assign o_bo_n = ~w_act.bo;
    assign o_io_n = ~w_act.io;
    assign o_co_n = ~w_act.co;
    assign o_eo_n = ~w_act.eo;
    assign o_ro_n = ~w_act.ro;
    assign o_no_n = ~w_act.no;

endmodule

// File: rtl/debug_port.sv
// Debug command engine: parses RX command frames, negotiates debug takeover
// with the core, executes one-cycle control words and returns a TX byte.
module debug_port
    import debug_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RESET,
    debug_port_if.slave s_byte,
    output logic       DEBUG_REQUEST,
    input  logic       DEBUG_ACK,
    output logic [7:0] DEBUG_DATA,
    output logic       D_CLR,
    output logic       D_HLT,
    output logic       D_CE,
    output logic       D_SU,
    output logic       D_RI,
    output logic       D_AIn,
    output logic       D_BIn,
    output logic       D_OIn,
    output logic       D_IIn,
    output logic       D_Jn,
    output logic       D_FIn,
    output logic       D_MIn,
    output logic       D_DOn,
    output logic       D_AOn,
    output logic       D_BOn,
    output logic       D_IOn,
    output logic       D_COn,
    output logic       D_EOn,
    output logic       D_ROn,
    output logic       D_NOn,
    input  logic [7:0] BUS,
    input  logic       HALTED,
    output state_t     o_dbg_state
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT);

    state_t     r_state,   w_state_nxt;
    logic [1:0] r_arg_idx, w_arg_idx_nxt;
    ctrl_word_t r_word,    w_word_nxt;
    logic [7:0] r_d,       w_d_nxt;
    logic [7:0] r_tx_data, w_tx_nxt;
    logic       r_req,     w_req_nxt;
    logic [CW-1:0] r_cnt,  w_cnt_nxt;
    logic       w_rx_ready;
    logic       w_tx_valid;
    logic       w_exec;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_arg_idx <= '0;
            r_word    <= '0;
            r_d       <= '0;
            r_tx_data <= '0;
            r_req     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arg_idx <= w_arg_idx_nxt;
            r_word    <= w_word_nxt;
            r_d       <= w_d_nxt;
            r_tx_data <= w_tx_nxt;
            r_req     <= w_req_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_arg_idx_nxt = r_arg_idx;
        w_word_nxt    = r_word;
        w_d_nxt       = r_d;
        w_tx_nxt      = r_tx_data;
        w_req_nxt     = r_req;
        w_cnt_nxt     = r_cnt;
        w_rx_ready    = 1'b0;
        w_tx_valid    = 1'b0;
        w_exec        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_rx_ready = 1'b1;
                if (s_byte.RX_VALID) begin
                    case (s_byte.RX_DATA)
                        CMD_EXEC: begin
                            w_state_nxt   = ST_ARGS;
                            w_arg_idx_nxt = '0;
                        end
                        CMD_ENTER: begin
                            w_state_nxt = ST_REQ;
                            w_req_nxt   = 1'b1;
                            w_cnt_nxt   = '0;
                        end
                        CMD_EXIT: begin
                            w_state_nxt = ST_REL;
                            w_req_nxt   = 1'b0;
                            w_cnt_nxt   = '0;
                        end
                        CMD_STATUS: begin
                            w_state_nxt = ST_RESP;
                            w_tx_nxt    = {6'b0, HALTED, DEBUG_ACK};
                        end
                        default: begin
                            w_state_nxt = ST_RESP;
                            w_tx_nxt    = RSP_BAD_CMD;
                        end
                    endcase
                end
            end
            ST_ARGS: begin
                w_rx_ready = 1'b1;
                if (s_byte.RX_VALID) begin
                    w_arg_idx_nxt = r_arg_idx + 2'd1;
                    case (r_arg_idx)
                        2'd0: begin
                            w_word_nxt.clr  = s_byte.RX_DATA[W0_CLR];
                            w_word_nxt.hlt  = s_byte.RX_DATA[W0_HLT];
                            w_word_nxt.ce   = s_byte.RX_DATA[W0_CE];
                            w_word_nxt.su   = s_byte.RX_DATA[W0_SU];
                            w_word_nxt.dato = s_byte.RX_DATA[W0_DO];
                        end
                        2'd1: begin
                            w_word_nxt.ai = s_byte.RX_DATA[W1_AI];
                            w_word_nxt.bi = s_byte.RX_DATA[W1_BI];
                            w_word_nxt.oi = s_byte.RX_DATA[W1_OI];
                            w_word_nxt.ii = s_byte.RX_DATA[W1_II];
                            w_word_nxt.j  = s_byte.RX_DATA[W1_J];
                            w_word_nxt.fi = s_byte.RX_DATA[W1_FI];
                            w_word_nxt.mi = s_byte.RX_DATA[W1_MI];
                            w_word_nxt.ri = s_byte.RX_DATA[W1_RI];
                        end
                        2'd2: begin
                            w_word_nxt.ao = s_byte.RX_DATA[W2_AO];
                            w_word_nxt.bo = s_byte.RX_DATA[W2_BO];
                            w_word_nxt.io = s_byte.RX_DATA[W2_IO];
                            w_word_nxt.co = s_byte.RX_DATA[W2_CO];
                            w_word_nxt.eo = s_byte.RX_DATA[W2_EO];
                            w_word_nxt.ro = s_byte.RX_DATA[W2_RO];
                            w_word_nxt.no = s_byte.RX_DATA[W2_NO];
                        end
                        default: begin
                            // Ack is judged at the edge that takes the D byte.
                            w_d_nxt = s_byte.RX_DATA;
                            if (DEBUG_ACK) begin
                                w_state_nxt = ST_EXEC;
                            end else begin
                                w_state_nxt = ST_RESP;
                                w_tx_nxt    = RSP_NOT_ACKED;
                            end
                        end
                    endcase
                end
            end
            ST_REQ: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (DEBUG_ACK) begin
                    w_state_nxt = ST_RESP;
                    w_tx_nxt    = RSP_ENTER_OK;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = ST_RESP;
                    w_tx_nxt    = RSP_ENTER_TO;
                    w_req_nxt   = 1'b0;
                end
            end
            ST_EXEC: begin
                w_exec      = 1'b1;
                w_tx_nxt    = BUS;
                w_state_nxt = ST_RESP;
            end
            ST_REL: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (!DEBUG_ACK) begin
                    w_state_nxt = ST_RESP;
                    w_tx_nxt    = RSP_EXIT_OK;
                end else if (r_cnt == TO_LAST) begin
                    w_state_nxt = ST_RESP;
                    w_tx_nxt    = RSP_EXIT_TO;
                end
            end
            ST_RESP: begin
                w_tx_valid = 1'b1;
                if (s_byte.TX_READY) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // RX_READY is forced low while reset is held, even once the state is IDLE.
    assign s_byte.RX_READY = w_rx_ready & ~RESET;
    assign s_byte.TX_VALID = w_tx_valid;
    assign s_byte.TX_DATA  = r_tx_data;
    assign DEBUG_REQUEST   = r_req;
    assign o_dbg_state     = r_state;

    debug_word_drive u_word_drive (
        .i_word (r_word),
        .i_data (r_d),
        .i_en   (w_exec),
        .o_clr  (D_CLR),
        .o_hlt  (D_HLT),
        .o_ce   (D_CE),
        .o_su   (D_SU),
        .o_ri   (D_RI),
        .o_ai_n (D_AIn),
        .o_bi_n (D_BIn),
        .o_oi_n (D_OIn),
        .o_ii_n (D_IIn),
        .o_j_n  (D_Jn),
        .o_fi_n (D_FIn),
        .o_mi_n (D_MIn),
        .o_do_n (D_DOn),
        .o_ao_n (D_AOn),
        .o_bo_n (D_BOn),
        .o_io_n (D_IOn),
        .o_co_n (D_COn),
        .o_eo_n (D_EOn),
        .o_ro_n (D_ROn),
        .o_no_n (D_NOn),
        .o_data (DEBUG_DATA)
    );

endmodule

// File: tb/tb_debug_port.sv
// Directed bench for debug_port: a small core model (ack follower, bus source)
// plus a response/control-word model checked every cycle.
`timescale 1ns/1ps
module tb_debug_port;
    import debug_pkg::*;

    localparam int ACK_TIMEOUT = 8;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    debug_port_if bif();

    logic       DEBUG_REQUEST;
    logic       DEBUG_ACK = 1'b0;
    logic [7:0] DEBUG_DATA;
    logic D_CLR, D_HLT, D_CE, D_SU, D_RI;
    logic D_AIn, D_BIn, D_OIn, D_IIn, D_Jn, D_FIn, D_MIn, D_DOn;
    logic D_AOn, D_BOn, D_IOn, D_COn, D_EOn, D_ROn, D_NOn;
    logic [7:0] BUS;
    logic       HALTED;
    logic [7:0] bus_idle;
    state_t     dbg_state;

    // Core model: puts DEBUG_DATA on the bus when DO is asserted.
    assign BUS = D_DOn ? bus_idle : DEBUG_DATA;

    debug_port #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .s_byte(bif),
        .DEBUG_REQUEST(DEBUG_REQUEST), .DEBUG_ACK(DEBUG_ACK), .DEBUG_DATA(DEBUG_DATA),
        .D_CLR(D_CLR), .D_HLT(D_HLT), .D_CE(D_CE), .D_SU(D_SU), .D_RI(D_RI),
        .D_AIn(D_AIn), .D_BIn(D_BIn), .D_OIn(D_OIn), .D_IIn(D_IIn), .D_Jn(D_Jn),
        .D_FIn(D_FIn), .D_MIn(D_MIn), .D_DOn(D_DOn), .D_AOn(D_AOn), .D_BOn(D_BOn),
        .D_IOn(D_IOn), .D_COn(D_COn), .D_EOn(D_EOn), .D_ROn(D_ROn), .D_NOn(D_NOn),
        .BUS(BUS), .HALTED(HALTED), .o_dbg_state(dbg_state)
    );

    // Asserted-level view of the pins, ordered W0[7:3], W1[7:0], W2[7:1].
    logic [19:0] dut_asserted;
    assign dut_asserted = {D_CLR, D_HLT, D_CE, D_SU, ~D_DOn,
                           ~D_AIn, ~D_BIn, ~D_OIn, ~D_IIn, ~D_Jn, ~D_FIn, ~D_MIn, D_RI,
                           ~D_AOn, ~D_BOn, ~D_IOn, ~D_COn, ~D_EOn, ~D_ROn, ~D_NOn};

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_tx = 8'h00;
    logic        exp_exec = 1'b0;
    logic [19:0] exp_assert = '0;
    logic [7:0]  exp_dd = 8'h00;
    logic [19:0] seen_assert = '0;
    logic [7:0]  seen_dd = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Core ack model: ack rises ack_delay cycles after the request (if enabled),
    // and falls one cycle after the request drops.
    int   ack_delay = 3;
    logic ack_en = 1'b1;
    int   ack_cnt = 0;
    logic prev_req = 1'b0;
    always @(posedge CLK) begin
        #1;
        if (DEBUG_REQUEST) begin
            if (ack_en && !DEBUG_ACK) begin
                if (ack_cnt >= ack_delay) DEBUG_ACK = 1'b1;
                else ack_cnt++;
            end
        end else begin
            ack_cnt = 0;
            if (!prev_req) DEBUG_ACK = 1'b0;
        end
        prev_req = DEBUG_REQUEST;
    end

    // Compare process: control pins every cycle, TX bytes on each handshake.
    logic [19:0] want_assert;
    logic [7:0]  want_dd;
    logic [7:0]  want_tx;
    always @(negedge CLK) begin
        if (!RESET) begin
            if (exp_exec) begin
                want_assert = exp_assert;
                want_dd     = exp_dd;
                seen_assert = dut_asserted;
                seen_dd     = DEBUG_DATA;
                exp_exec    = 1'b0;
            end else begin
                want_assert = '0;
                want_dd     = 8'h00;
            end
            check("d_word", dut_asserted, want_assert);
            check("debug_data", DEBUG_DATA, want_dd);
            if (bif.TX_VALID && bif.TX_READY) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_tx: got 0x%0h, expected no response", bif.TX_DATA);
                end else begin
                    want_tx = exp_q.pop_front();
                    last_tx = bif.TX_DATA;
                    if (bif.TX_DATA !== want_tx) begin
                        n_bad++;
                        $display("FAIL tx_data: got 0x%0h, expected 0x%0h", bif.TX_DATA, want_tx);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, output logic ack_at);
        int n;
        @(negedge CLK);
        bif.RX_DATA  = b;
        bif.RX_VALID = 1'b1;
        n = 0;
        while (!bif.RX_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("rx_accept", bif.RX_READY, 1);
        ack_at = DEBUG_ACK;
        @(posedge CLK);
        #1;
        bif.RX_VALID = 1'b0;
    endtask

    // Single-byte command with its response predicted from the command rules.
    task automatic send_cmd(input logic [7:0] cmd);
        logic a;
        send_byte(cmd, a);
        case (cmd)
            CMD_ENTER:  exp_q.push_back((a || ack_en) ? RSP_ENTER_OK : RSP_ENTER_TO);
            CMD_EXIT:   exp_q.push_back(RSP_EXIT_OK);
            CMD_STATUS: exp_q.push_back({6'b0, HALTED, a});
            default:    exp_q.push_back(RSP_BAD_CMD);
        endcase
    endtask

    task automatic do_exec(input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] d);
        logic a;
        send_byte(CMD_EXEC, a);
        send_byte(w0, a);
        send_byte(w1, a);
        send_byte(w2, a);
        send_byte(d, a);
        if (a) begin
            exp_q.push_back(w0[3] ? d : bus_idle);
            exp_assert = {w0[7:3], w1, w2[7:1]};
            exp_dd     = d;
            exp_exec   = 1'b1;
            check("exec_tx_not_yet", bif.TX_VALID, 0);
            @(posedge CLK);
            #1;
            check("exec_tx_latency", bif.TX_VALID, 1);
        end else begin
            exp_q.push_back(RSP_NOT_ACKED);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge CLK);
        while ((exp_q.size() != 0 || bif.TX_VALID) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check("wait_idle_budget", (n < 300), 1);
        exp_q.delete();
    endtask

    initial begin
        int k;
        logic a;
        bif.RX_DATA  = 8'h00;
        bif.RX_VALID = 1'b0;
        bif.TX_READY = 1'b1;
        HALTED   = 1'b1;
        bus_idle = 8'hC3;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_rx_ready", bif.RX_READY, 0);
        check("rst_tx_valid", bif.TX_VALID, 0);
        check("rst_tx_data", bif.TX_DATA, 0);
        check("rst_req", DEBUG_REQUEST, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_idle_word", dut_asserted, 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rx_ready_after_rst", bif.RX_READY, 1);

        // STATUS with HALTED=1, not acked
        send_cmd(CMD_STATUS);
        wait_idle();
        check("status_lit", last_tx, 8'h02);
        check("status_req", DEBUG_REQUEST, 0);

        // ENTER, core acks 3 cycles later
        ack_en = 1'b1;
        send_cmd(CMD_ENTER);
        check("enter_req_rise", DEBUG_REQUEST, 1);
        wait_idle();
        check("enter_lit", last_tx, 8'hA5);
        check("enter_req_hold", DEBUG_REQUEST, 1);

        // EXEC with DO + AI, D on the bus
        do_exec(8'h08, 8'h80, 8'h00, 8'h3C);
        wait_idle();
        check("exec1_tx_lit", last_tx, 8'h3C);
        check("exec1_word_lit", seen_assert, 20'h0C000);
        check("exec1_data_lit", seen_dd, 8'h3C);

        // EXEC with every other control asserted, DO off: bus idles
        do_exec(8'hF0, 8'h01, 8'hFE, 8'h55);
        wait_idle();
        check("exec2_tx_lit", last_tx, 8'hC3);
        check("exec2_word_lit", seen_assert, 20'hF00FF);

        // EXIT: request drops at once, ack follows a cycle later
        send_cmd(CMD_EXIT);
        check("exit_req_fall", DEBUG_REQUEST, 0);
        wait_idle();
        check("exit_lit", last_tx, 8'h5A);

        // EXEC while not acked
        do_exec(8'h08, 8'h80, 8'h00, 8'h3C);
        wait_idle();
        check("exec_noack_lit", last_tx, 8'hE1);

        // ENTER with no ack ever: timeout
        ack_en = 1'b0;
        send_byte(CMD_ENTER, a);
        exp_q.push_back(RSP_ENTER_TO);
        k = 0;
        while (!bif.TX_VALID && k < 50) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check("timeout_latency", k, ACK_TIMEOUT + 1);
        wait_idle();
        check("timeout_lit", last_tx, 8'hE2);
        check("timeout_req_drop", DEBUG_REQUEST, 0);

        // EXIT while not acked, unknown code
        send_cmd(CMD_EXIT);
        wait_idle();
        check("exit_noack_lit", last_tx, 8'h5A);
        send_cmd(8'h7F);
        wait_idle();
        check("bad_cmd_lit", last_tx, 8'hEE);

        // ENTER, then ENTER while already acked, then STATUS
        ack_en = 1'b1;
        send_cmd(CMD_ENTER);
        wait_idle();
        send_cmd(CMD_ENTER);
        wait_idle();
        check("reenter_lit", last_tx, 8'hA5);
        HALTED = 1'b0;
        send_cmd(CMD_STATUS);
        wait_idle();
        check("status_acked_lit", last_tx, 8'h01);

        // TX back-pressure for 10 cycles
        HALTED = 1'b1;
        bif.TX_READY = 1'b0;
        send_cmd(CMD_STATUS);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("stall_valid", bif.TX_VALID, 1);
            check("stall_data", bif.TX_DATA, 8'h03);
            check("stall_rx_ready", bif.RX_READY, 0);
        end
        bif.TX_READY = 1'b1;
        wait_idle();
        check("stall_lit", last_tx, 8'h03);

        // Reset in the middle of EXEC arguments
        send_byte(CMD_EXEC, a);
        send_byte(8'h08, a);
        send_byte(8'h80, a);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("midrst_tx_valid", bif.TX_VALID, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        check("midrst_req", DEBUG_REQUEST, 0);
        check("midrst_rx_ready", bif.RX_READY, 1);
        repeat (4) @(negedge CLK);
        send_cmd(CMD_STATUS);
        wait_idle();
        check("post_rst_status_lit", last_tx, 8'h02);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
